// File: rtl/sass_tone_pkg.sv
// Shared note codes, phase increments and FSM state type for the sequencer tone path.
package sass_tone_pkg;

  localparam int ACC_W = 16;

  typedef enum logic [3:0] {
    OFF   = 4'd0,
    lowC  = 4'd1,
    Cs4   = 4'd2,
    D4    = 4'd3,
    Ds4   = 4'd4,
    E4    = 4'd5,
    F4    = 4'd6,
    Fs4   = 4'd7,
    G4    = 4'd8,
    Gs4   = 4'd9,
    A4    = 4'd10,
    As4   = 4'd11,
    B4    = 4'd12,
    highC = 4'd13
  } note_e;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } tone_state_e;

  function automatic logic note_valid(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd13);
  endfunction

  // round(f * 65536 / 10000) for the 10 kHz clock
  function automatic logic [ACC_W-1:0] inc_of(input logic [3:0] code);
    logic [ACC_W-1:0] inc;
    case (code)
      4'd1:    inc = 16'd1715;
      4'd2:    inc = 16'd1817;
      4'd3:    inc = 16'd1925;
      4'd4:    inc = 16'd2039;
      4'd5:    inc = 16'd2160;
      4'd6:    inc = 16'd2289;
      4'd7:    inc = 16'd2425;
      4'd8:    inc = 16'd2569;
      4'd9:    inc = 16'd2722;
      4'd10:   inc = 16'd2884;
      4'd11:   inc = 16'd3055;
      4'd12:   inc = 16'd3237;
      4'd13:   inc = 16'd3429;
      default: inc = 16'd0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/tone_phase_acc.sv
// Wrapping phase accumulator; the MSB is the square-wave output.
module tone_phase_acc
  import sass_tone_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             msb_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + inc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    acc_q <= acc_d;
  end

  assign msb_o = acc_q[ACC_W-1];

endmodule

// File: rtl/note_tone_generator.sv
// Note latch / hold FSM driving a phase accumulator into a square-wave tone.
// Define TONE_SUSTAIN_EN to keep a note sounding for SUSTAIN_CYCLES after its last code.
module note_tone_generator
  import sass_tone_pkg::*;
#(
  parameter int unsigned SUSTAIN_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] note_in,
  output logic       tone_out,
  output logic       active,
  output logic [3:0] cur_note
);

  if ((SUSTAIN_CYCLES < 1) || (SUSTAIN_CYCLES > 65535)) begin : g_bad_sustain
    $error("SUSTAIN_CYCLES must be in 1..65535");
  end

  tone_state_e state_q, state_d;
  logic [3:0]  note_q, note_d;
  logic        acc_clr;
  logic        acc_en;
  logic        valid;

`ifdef TONE_SUSTAIN_EN
  localparam logic [15:0] HOLD_RELOAD = 16'(SUSTAIN_CYCLES - 1);
  logic [15:0] hold_q, hold_d;
`endif

  assign valid = note_valid(note_in);

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
`ifdef TONE_SUSTAIN_EN
    hold_d  = hold_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      note_d  = 4'd0;
      acc_clr = 1'b1;
`ifdef TONE_SUSTAIN_EN
      hold_d  = '0;
`endif
    end else if (valid && ((state_q == IDLE) || (note_in != note_q))) begin
      // New note: restart the phase so every note begins on a low half-cycle
      state_d = PLAY;
      note_d  = note_in;
      acc_clr = 1'b1;
`ifdef TONE_SUSTAIN_EN
      hold_d  = HOLD_RELOAD;
`endif
    end else if (valid) begin
      acc_en = 1'b1;
`ifdef TONE_SUSTAIN_EN
      hold_d = HOLD_RELOAD;
`endif
    end else if (state_q == PLAY) begin
`ifdef TONE_SUSTAIN_EN
      if (hold_q == 16'd0) begin
        state_d = IDLE;
        note_d  = 4'd0;
        acc_clr = 1'b1;
      end else begin
        hold_d = hold_q - 16'd1;
        acc_en = 1'b1;
      end
`else
      state_d = IDLE;
      note_d  = 4'd0;
      acc_clr = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= 4'd0;
`ifdef TONE_SUSTAIN_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
`ifdef TONE_SUSTAIN_EN
      hold_q  <= hold_d;
`endif
    end
  end

  tone_phase_acc u_acc (
    .clk_i (clk),
    .clr_i (rst | acc_clr),
    .en_i  (acc_en),
    .inc_i (inc_of(note_q)),
    .msb_o (tone_out)
  );

  assign active   = (state_q == PLAY);
  assign cur_note = note_q;

endmodule

// File: tb/tb_note_tone_generator.sv
// Directed checks of note latching, sustain/gating, tone edge timing and enable clear.
module tb_note_tone_generator;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] note_in;
  logic       tone_out;
  logic       active;
  logic [3:0] cur_note;

  int vec_cnt;
  int err_cnt;

  note_tone_generator dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .note_in  (note_in),
    .tone_out (tone_out),
    .active   (active),
    .cur_note (cur_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_act"},  int'(active),   0);
    check({tag, "_note"}, int'(cur_note), 0);
    check({tag, "_tone"}, int'(tone_out), 0);
  endtask

  // Runs n edges with the current inputs; k counts from 1 after the caller's sample.
  task automatic run_play(input int n, output int act, output int rise, output int fall);
    act  = 0;
    rise = -1;
    fall = -1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (active) act++;
      if (tone_out && rise < 0) rise = k;
      if (!tone_out && rise >= 0 && fall < 0) fall = k;
    end
  endtask

  int act, rise, fall;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    enable  = 1'b1;
    note_in = 4'd10;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
    end
    rst     = 1'b0;
    note_in = 4'd14;
    run_play(3, act, rise, fall);
    check("inv14_act_cycles", act, 0);
    check_idle("inv14");
    note_in = 4'd15;
    tick();
    check_idle("inv15");

`ifdef TONE_SUSTAIN_EN
    // single pulse of A
    note_in = 4'd10;
    tick();
    check("pulse_note", int'(cur_note), 10);
    check("pulse_act",  int'(active),   1);
    check("pulse_tone0", int'(tone_out), 0);
    note_in = 4'd0;
    run_play(2500, act, rise, fall);
    check("pulse_act_cycles", act + 1, 2500);
    check("pulse_rise", rise, 12);
    check("pulse_fall", fall, 23);
    check_idle("pulse_end");

    // retrigger 1 -> 13
    note_in = 4'd1;
    tick();
    check("rt_note1", int'(cur_note), 1);
    run_play(99, act, rise, fall);
    check("rt_rise1", rise, 20);
    check("rt_fall1", fall, 39);
    check("rt_tone_before", int'(tone_out), 1);
    note_in = 4'd13;
    tick();
    check("rt_note13", int'(cur_note), 13);
    check("rt_tone_reset", int'(tone_out), 0);
    note_in = 4'd0;
    run_play(2500, act, rise, fall);
    check("rt_act_cycles", act + 1, 2500);
    check("rt_rise13", rise, 10);
    check_idle("rt_end");

    // same-note refresh keeps phase
    note_in = 4'd5;
    tick();
    note_in = 4'd0;
    run_play(1999, act, rise, fall);
    check("rf_rise", rise, 16);
    note_in = 4'd5;
    tick();
    check("rf_tone_2000", int'(tone_out), 1);
    note_in = 4'd0;
    run_play(3, act, rise, fall);
    check("rf_tone_2003", int'(tone_out), 0);
    run_play(2497, act, rise, fall);
    check("rf_act_tail", act, 2496);
    check_idle("rf_end");
`else
    // gated tone: note 8 held for 50 cycles
    note_in = 4'd8;
    tick();
    check("g_note", int'(cur_note), 8);
    check("g_act",  int'(active),   1);
    check("g_tone0", int'(tone_out), 0);
    run_play(49, act, rise, fall);
    check("g_act_cycles", act + 1, 50);
    check("g_rise", rise, 13);
    check("g_fall", fall, 26);
    note_in = 4'd0;
    tick();
    check_idle("g_off");

    // held change 1 -> 13
    note_in = 4'd1;
    tick();
    run_play(99, act, rise, fall);
    check("rt_rise1", rise, 20);
    check("rt_tone_before", int'(tone_out), 1);
    note_in = 4'd13;
    tick();
    check("rt_note13", int'(cur_note), 13);
    check("rt_tone_reset", int'(tone_out), 0);
    run_play(20, act, rise, fall);
    check("rt_act", act, 20);
    check("rt_rise13", rise, 10);
    note_in = 4'd0;
    tick();
    check_idle("rt_off");
`endif

    // enable drop mid-note, then wait for a fresh code
    note_in = 4'd3;
    tick();
    check("en_note", int'(cur_note), 3);
`ifdef TONE_SUSTAIN_EN
    note_in = 4'd0;
`endif
    run_play(18, act, rise, fall);
    check("en_rise", rise, 18);
    note_in = 4'd0;
    enable  = 1'b0;
    tick();
    check_idle("en_drop");
    enable = 1'b1;
    run_play(10, act, rise, fall);
    check("en_wait_act", act, 0);
    check("en_wait_rise", rise, -1);
    note_in = 4'd3;
    tick();
    check("en_relatch", int'(cur_note), 3);
    check("en_relatch_act", int'(active), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
